// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   start   - request strobe; MDUOp/dInA/dInB are sampled with it
//   cancel  - abandon the operation in flight (pipeline flush)
//   MDUOp   - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   dInA    - R[rs], multiplicand / dividend / mthi-mtlo source
//   dInB    - R[rt], multiplier / divisor
//   busy    - operation in progress (stalls mfhi/mflo and later mul/div)
//   done    - one-cycle pulse after HI/LO were written by mul/div
//   hi, lo  - HI/LO result registers
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       MDUOp;
  logic [WIDTH-1:0] dInA;
  logic [WIDTH-1:0] dInB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, MDUOp, dInA, dInB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, cancel, MDUOp, dInA, dInB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative (one bit per cycle) multiply/divide unit with HI/LO
// registers for the MIPS execute stage.
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mul_div_unit_if slave: start/cancel/MDUOp/dInA/dInB in,
//           busy/done/hi/lo out
// Signed ops work on operand magnitudes and fix the signs in the FIX state.
// Multiply is shift-add, divide is restoring; both share one 2*WIDTH register.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Absolute value when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    if (is_signed && x[WIDTH-1]) magnitude = -x;
    else                         magnitude = x;
  endfunction

  // Conditional two's-complement negation, single width.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    if (neg) cond_neg = -x;
    else     cond_neg = x;
  endfunction

  // Conditional two's-complement negation, double width.
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                   input logic neg);
    if (neg) cond_neg2 = -x;
    else     cond_neg2 = x;
  endfunction

  state_t             state_r, state_next_s;
  logic [CW-1:0]      count_r, count_next_s;
  logic [2*WIDTH-1:0] acc_r, step_s, prod_fix_s;
  logic [WIDTH-1:0]   opb_r, a_save_r, hi_r, lo_r, hi_fix_s, lo_fix_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s, div_diff_s;
  logic               is_div_r, neg_res_r, neg_rem_r, div_zero_r;
  logic               busy_r, done_r;
  logic               accept_arith_s, accept_mt_s;
  logic               op_signed_s;

  assign count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
  assign op_signed_s  = ~bus.MDUOp[0];

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Request acceptance: only in IDLE, and cancel drops a same-cycle request.
  always_comb begin
    accept_arith_s = 1'b0;
    accept_mt_s    = 1'b0;
    if (state_r == IDLE && bus.start && !bus.cancel) begin
      accept_arith_s = ~bus.MDUOp[2];
      accept_mt_s    = bus.MDUOp[2] & ~bus.MDUOp[1];
    end else begin
      accept_arith_s = 1'b0;
      accept_mt_s    = 1'b0;
    end
  end

  // Next-state logic; cancel returns to IDLE from any state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_arith_s) state_next_s = RUN;
        else                state_next_s = IDLE;
      end
      RUN: begin
        if (bus.cancel)                        state_next_s = IDLE;
        else if (count_next_s == CW'(WIDTH))   state_next_s = FIX;
        else                                   state_next_s = RUN;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    // Divide: partial remainder shifted left with the next dividend bit.
    div_trial_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_trial_s - {1'b0, opb_r};
    if (is_div_r) begin
      if (div_diff_s[WIDTH]) step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      else                   step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero result selection for writeback.
  always_comb begin
    prod_fix_s = cond_neg2(acc_r, neg_res_r);
    if (!is_div_r) begin
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end else if (div_zero_r) begin
      hi_fix_s = a_save_r;
      lo_fix_s = {WIDTH{1'b1}};
    end else begin
      // Quotient sign from operand signs, remainder follows the dividend.
      hi_fix_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
      lo_fix_s = cond_neg(acc_r[WIDTH-1:0], neg_res_r);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r    <= '0;
      acc_r      <= '0;
      opb_r      <= '0;
      a_save_r   <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_arith_s) begin
            is_div_r   <= bus.MDUOp[1];
            neg_res_r  <= op_signed_s & (bus.dInA[WIDTH-1] ^ bus.dInB[WIDTH-1]);
            neg_rem_r  <= op_signed_s & bus.dInA[WIDTH-1];
            div_zero_r <= bus.MDUOp[1] & (bus.dInB == {WIDTH{1'b0}});
            a_save_r   <= bus.dInA;
            count_r    <= '0;
            if (bus.MDUOp[1]) begin
              acc_r <= {{WIDTH{1'b0}}, magnitude(bus.dInA, op_signed_s)};
              opb_r <= magnitude(bus.dInB, op_signed_s);
            end else begin
              acc_r <= {{WIDTH{1'b0}}, magnitude(bus.dInB, op_signed_s)};
              opb_r <= magnitude(bus.dInA, op_signed_s);
            end
          end else if (accept_mt_s) begin
            if (bus.MDUOp[0]) lo_r <= bus.dInA;
            else              hi_r <= bus.dInA;
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            acc_r   <= step_s;
            count_r <= count_next_s;
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            hi_r   <= hi_fix_s;
            lo_r   <= lo_fix_s;
            done_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit (WIDTH=32)
// against a plain-arithmetic reference model of HI/LO results.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  logic [31:0] m_hi, m_lo;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result {hi, lo} from ordinary integer arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sp;
    int sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); r = sp; end
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  // Issue an arithmetic op at the current negedge and follow it to done.
  task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit check_pulse);
    logic [63:0] exp;
    int cyc;
    exp = ref_mdu(op, a, b);
    bus.start = 1'b1; bus.MDUOp = op; bus.dInA = a; bus.dInB = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp[63:32]});
    chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp[31:0]});
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    if (check_pulse) begin
      @(negedge clk);
      chk({tag, "_done_fall"}, {63'd0, bus.done}, 64'd0);
    end
  endtask

  // mthi/mtlo (or a no-op) issued at the current negedge.
  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    bus.start = 1'b1; bus.MDUOp = op; bus.dInA = a; bus.dInB = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    if (op == 3'b100) m_hi = a;
    if (op == 3'b101) m_lo = a;
    chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int done_seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.MDUOp = 3'b110;
    bus.dInA = 32'd0; bus.dInB = 32'd0;
    rst_n = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed results; the later ones run back-to-back from the done cycle.
    run_arith("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_arith("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_arith("divu_7_2", 3'd3, 32'd7, 32'd2, 1'b0);
    run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_arith("div_by0", 3'd2, 32'h1234_5678, 32'd0, 1'b0);
    run_arith("divu_by0", 3'd3, 32'h1234_5678, 32'd0, 1'b1);

    // Preload HI/LO, then cancel a mult after an ignored start.
    run_mt("mthi", 3'b100, 32'hAAAA_5555);
    run_mt("mtlo", 3'b101, 32'h0000_1234);
    bus.start = 1'b1; bus.MDUOp = 3'd0; bus.dInA = 32'd3; bus.dInB = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = 3'd3; bus.dInA = 32'd7; bus.dInB = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", {63'd0, bus.busy}, 64'd0);
    chk("cancel_done", {63'd0, bus.done}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    chk("cancel_quiet", 64'(done_seen), 64'd0);
    chk("cancel_hi", {32'd0, bus.hi}, 64'hAAAA_5555);
    chk("cancel_lo", {32'd0, bus.lo}, 64'h0000_1234);

    // Cancel during the FIX cycle must suppress the write.
    bus.start = 1'b1; bus.MDUOp = 3'd3; bus.dInA = 32'd100; bus.dInB = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("fixcancel_busy", {63'd0, bus.busy}, 64'd0);
    chk("fixcancel_done", {63'd0, bus.done}, 64'd0);
    chk("fixcancel_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    chk("fixcancel_lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Cancel beats a same-cycle mthi; a 110 op does nothing.
    bus.cancel = 1'b1;
    run_mt("cancel_mthi", 3'b111, 32'h0000_5A5A);
    bus.cancel = 1'b0;
    bus.start = 1'b1; bus.MDUOp = 3'b100; bus.dInA = 32'h0000_5A5A; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("cancel_mthi_drop", {32'd0, bus.hi}, {32'd0, m_hi});
    run_mt("noop110", 3'b110, 32'hDEAD_BEEF);

    // Reset during iteration 20 of a div.
    bus.start = 1'b1; bus.MDUOp = 3'd2; bus.dInA = 32'd1000; bus.dInB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
    chk("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_arith("multu_6x7", 3'd1, 32'd6, 32'd7, 1'b1);

    // Random ops with corner-biased operands.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_arith($sformatf("rand%0d", i), rop, ra, rb, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
